// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ack
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory loads/stores over req/ack, stalls upstream
// while busy, and registers the MEM/WB writeback. Optional access timeout: MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  mem_sw_o,
    input  logic [DATA_W-1:0]  mem_write_o,
    input  logic               mem_lwsrc,
    input  logic               mem_movsrc,
    input  logic [RADDR_W-1:0] mem_write_addr_o,
    input  logic               mem_reg_write,
    input  logic               mem_DM_read,
    input  logic               mem_DM_write,
    input  logic [DATA_W-1:0]  mem_alu_result,
    mem_stage_if.master        dm_bus,
    output logic               mem_stall,
    output logic [DATA_W-1:0]  wb_write_data,
    output logic [RADDR_W-1:0] wb_write_addr,
    output logic               wb_reg_write,
    output logic               mem_fault
);

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("mem_stage: TIMEOUT must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic [RADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic               wb_we_q, wb_we_d;
    logic               fault_q, fault_d;
    logic               access_c;
    logic               timeout_c;
    logic [DATA_W-1:0]  wb_mux_c;

    assign access_c = mem_DM_read | mem_DM_write;
    assign wb_mux_c = mem_lwsrc  ? dm_bus.dm_rdata :
                      mem_movsrc ? mem_write_o     : mem_alu_result;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts unacknowledged BUSY cycles; held at zero outside BUSY so entry starts clean.
    always_comb begin
        cnt_d = '0;
        if (state_q == BUSY && !dm_bus.dm_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_c = (state_q == BUSY) && (cnt_q == CNT_LAST);
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state, memory request and MEM/WB register inputs.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        wb_we_d   = 1'b0;
        fault_d   = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_c) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = mem_DM_write;
                    addr_d    = mem_alu_result;
                    wdata_d   = mem_sw_o;
                    state_d   = BUSY;
                end else begin
                    wb_data_d = wb_mux_c;
                    wb_addr_d = mem_write_addr_o;
                    wb_we_d   = mem_reg_write;
                end
            end
            BUSY: begin
                if (dm_bus.dm_ack) begin
                    wb_data_d = wb_mux_c;
                    wb_addr_d = mem_write_addr_o;
                    wb_we_d   = mem_reg_write;
                    req_d     = 1'b0;
                    state_d   = IDLE;
                end else if (timeout_c) begin
                    // Abandon the access: release upstream with a bubble and flag it.
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_we_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            wb_we_q   <= wb_we_d;
            fault_q   <= fault_d;
        end
    end

    assign dm_bus.dm_req   = req_q;
    assign dm_bus.dm_we    = we_q;
    assign dm_bus.dm_addr  = addr_q;
    assign dm_bus.dm_wdata = wdata_q;
    assign wb_write_data   = wb_data_q;
    assign wb_write_addr   = wb_addr_q;
    assign wb_reg_write    = wb_we_q;
    assign mem_fault       = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan items plus random instruction stream
// against a transaction-level model; timeout checks when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] sw;
        logic [31:0] wo;
        logic [31:0] alu;
        logic        lw;
        logic        mov;
        logic        rw;
        logic        rd;
        logic        wr;
        logic [4:0]  wa;
    } instr_t;

    logic               clk;
    logic               rst;
    logic [DATA_W-1:0]  mem_sw_o;
    logic [DATA_W-1:0]  mem_write_o;
    logic               mem_lwsrc;
    logic               mem_movsrc;
    logic [RADDR_W-1:0] mem_write_addr_o;
    logic               mem_reg_write;
    logic               mem_DM_read;
    logic               mem_DM_write;
    logic [DATA_W-1:0]  mem_alu_result;
    logic               mem_stall;
    logic [DATA_W-1:0]  wb_write_data;
    logic [RADDR_W-1:0] wb_write_addr;
    logic               wb_reg_write;
    logic               mem_fault;

    mem_stage_if #(.DATA_W(DATA_W)) dm_bus ();

    mem_stage #(
        .DATA_W (DATA_W),
        .RADDR_W(RADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_sw_o        (mem_sw_o),
        .mem_write_o     (mem_write_o),
        .mem_lwsrc       (mem_lwsrc),
        .mem_movsrc      (mem_movsrc),
        .mem_write_addr_o(mem_write_addr_o),
        .mem_reg_write   (mem_reg_write),
        .mem_DM_read     (mem_DM_read),
        .mem_DM_write    (mem_DM_write),
        .mem_alu_result  (mem_alu_result),
        .dm_bus          (dm_bus),
        .mem_stall       (mem_stall),
        .wb_write_data   (wb_write_data),
        .wb_write_addr   (wb_write_addr),
        .wb_reg_write    (wb_reg_write),
        .mem_fault       (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_wd   = 32'd0;
    logic [4:0]  exp_wa   = 5'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Writeback selection as the pipeline defines it.
    function automatic logic [31:0] wb_value(input instr_t i, input logic [31:0] ld);
        if (i.lw)  return ld;
        if (i.mov) return i.wo;
        return i.alu;
    endfunction

    function automatic instr_t mk(input logic [31:0] alu, input logic [4:0] wa, input logic rw);
        instr_t i;
        i     = '0;
        i.alu = alu;
        i.wa  = wa;
        i.rw  = rw;
        return i;
    endfunction

    function automatic instr_t rand_instr(input bit mem);
        instr_t i;
        int     kind;
        i.sw  = $urandom;
        i.wo  = $urandom;
        i.alu = $urandom;
        i.wa  = 5'($urandom);
        i.rw  = 1'($urandom);
        i.mov = 1'($urandom);
        i.lw  = 1'b0;
        i.rd  = 1'b0;
        i.wr  = 1'b0;
        if (mem) begin
            kind = $urandom_range(0, 2);
            i.rd = (kind != 1);
            i.wr = (kind != 0);
            i.lw = i.rd ? 1'($urandom) : 1'b0;
        end
        return i;
    endfunction

    task automatic apply(input instr_t i);
        mem_sw_o         = i.sw;
        mem_write_o      = i.wo;
        mem_alu_result   = i.alu;
        mem_lwsrc        = i.lw;
        mem_movsrc       = i.mov;
        mem_reg_write    = i.rw;
        mem_DM_read      = i.rd;
        mem_DM_write     = i.wr;
        mem_write_addr_o = i.wa;
    endtask

    task automatic check_wb(input string tag, input logic we);
        check({tag, "_wdata"}, wb_write_data, exp_wd);
        check({tag, "_waddr"}, 32'(wb_write_addr), 32'(exp_wa));
        check({tag, "_wen"}, 32'(wb_reg_write), 32'(we));
    endtask

    // Presents one instruction at posedge+1 and follows it through to writeback;
    // memory ops are acknowledged after 'waits' BUSY cycles, stray acks hit cycle 0.
    task automatic run_instr(input instr_t i, input int waits, input logic [31:0] rdata,
                             input logic stray);
        logic acc;
        acc = i.rd | i.wr;
        apply(i);
        dm_bus.dm_rdata = ~rdata;
        dm_bus.dm_ack   = stray;
        #1;
        check("stall_c0", 32'(mem_stall), 32'(acc));
        @(posedge clk); #1;
        dm_bus.dm_ack = 1'b0;
        if (!acc) begin
            exp_wd = wb_value(i, ~rdata);
            exp_wa = i.wa;
            check_wb("alu", i.rw);
            check("alu_req", 32'(dm_bus.dm_req), 32'd0);
            check("alu_fault", 32'(mem_fault), 32'd0);
            return;
        end
        check_wb("bubble", 1'b0);
        for (int k = 0; k <= waits; k++) begin
            check("busy_req", 32'(dm_bus.dm_req), 32'd1);
            check("busy_we", 32'(dm_bus.dm_we), 32'(i.wr));
            check("busy_addr", dm_bus.dm_addr, i.alu);
            check("busy_wdata", dm_bus.dm_wdata, i.sw);
            if (k == waits) begin
                dm_bus.dm_ack   = 1'b1;
                dm_bus.dm_rdata = rdata;
            end
            #1;
            check("busy_stall", 32'(mem_stall), 32'(k != waits));
            @(posedge clk); #1;
            dm_bus.dm_ack = 1'b0;
            if (k < waits) check("wait_wen", 32'(wb_reg_write), 32'd0);
        end
        exp_wd = wb_value(i, rdata);
        exp_wa = i.wa;
        check_wb("ack", i.rw);
        check("ack_req", 32'(dm_bus.dm_req), 32'd0);
        check("ack_fault", 32'(mem_fault), 32'd0);
    endtask

    initial begin
        instr_t i;
        rst = 1'b0;
        apply('0);
        dm_bus.dm_rdata = '0;
        dm_bus.dm_ack   = 1'b0;
        #1;
        check("rst_req", 32'(dm_bus.dm_req), 32'd0);
        check_wb("rst", 1'b0);
        check("rst_fault", 32'(mem_fault), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // ALU op
        run_instr(mk(32'h0000_1234, 5'd5, 1'b1), 0, 32'h0, 1'b0);
        // Load with three wait cycles
        i = mk(32'h40, 5'd7, 1'b1); i.rd = 1'b1; i.lw = 1'b1;
        run_instr(i, 3, 32'hDEAD_BEEF, 1'b0);
        // Store acked on first BUSY cycle, no writeback
        i = mk(32'h80, 5'd9, 1'b0); i.wr = 1'b1; i.sw = 32'hA5A5_A5A5;
        run_instr(i, 0, 32'h1111_2222, 1'b0);
        // Move followed immediately by a load
        i = mk(32'h99, 5'd3, 1'b1); i.mov = 1'b1; i.wo = 32'h77;
        run_instr(i, 0, 32'h0, 1'b0);
        i = mk(32'h44, 5'd4, 1'b1); i.rd = 1'b1; i.lw = 1'b1;
        run_instr(i, 1, 32'h0BAD_F00D, 1'b0);
        // Read+write together is a store, writing back the ALU result
        i = mk(32'h1C, 5'd12, 1'b1); i.rd = 1'b1; i.wr = 1'b1; i.sw = 32'hC0FFEE;
        run_instr(i, 2, 32'h5555_AAAA, 1'b0);
        // Ack arriving on the last cycle before any timeout
        i = mk(32'h200, 5'd13, 1'b1); i.rd = 1'b1; i.lw = 1'b1;
        run_instr(i, int'(TIMEOUT) - 1, 32'h1357_9BDF, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after TIMEOUT BUSY cycles with a one-cycle fault
        i = mk(32'h300, 5'd14, 1'b1); i.rd = 1'b1; i.lw = 1'b1;
        apply(i);
        #1;
        check("to_stall_c0", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            check("to_req", 32'(dm_bus.dm_req), 32'd1);
            check("to_fault_early", 32'(mem_fault), 32'd0);
            #1;
            check("to_stall", 32'(mem_stall), 32'(k != int'(TIMEOUT) - 1));
            @(posedge clk); #1;
        end
        check("to_req_drop", 32'(dm_bus.dm_req), 32'd0);
        check("to_fault", 32'(mem_fault), 32'd1);
        check_wb("to", 1'b0);
        run_instr(mk(32'h5A, 5'd2, 1'b1), 0, 32'h0, 1'b0);
`else
        // Without the timeout, BUSY waits for as long as the memory takes
        i = mk(32'h300, 5'd14, 1'b1); i.rd = 1'b1; i.lw = 1'b1;
        run_instr(i, 25, 32'h2468_ACE0, 1'b0);
`endif

        // Asynchronous reset in the middle of an access
        run_instr(mk(32'hFACE, 5'd21, 1'b1), 0, 32'h0, 1'b0);
        i = mk(32'h40, 5'd7, 1'b1); i.rd = 1'b1; i.lw = 1'b1;
        apply(i);
        #1;
        @(posedge clk); #1;
        check("pre_rst_req", 32'(dm_bus.dm_req), 32'd1);
        apply(mk(32'h0, 5'd0, 1'b0));
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(dm_bus.dm_req), 32'd0);
        check("mid_rst_addr", dm_bus.dm_addr, 32'd0);
        check("mid_rst_we", 32'(dm_bus.dm_we), 32'd0);
        check("mid_rst_wdata", dm_bus.dm_wdata, 32'd0);
        check("mid_rst_stall", 32'(mem_stall), 32'd0);
        check("mid_rst_fault", 32'(mem_fault), 32'd0);
        exp_wd = 32'd0;
        exp_wa = 5'd0;
        check_wb("mid_rst", 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        // Stray acks in IDLE are ignored
        run_instr(mk(32'h0000_0ABC, 5'd11, 1'b1), 0, 32'h0, 1'b1);
        i = mk(32'h48, 5'd8, 1'b1); i.rd = 1'b1; i.lw = 1'b1;
        run_instr(i, 1, 32'h8765_4321, 1'b1);

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            i = rand_instr(1'($urandom));
            run_instr(i, $urandom_range(0, 4), $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the in-order pipeline, between the EXE/MEM pipeline register and the register-file writeback. It issues loads and stores to the data memory over a request/acknowledge handshake, and stalls the upstream stages while an access is outstanding. It selects the writeback value (load data, move data or ALU result) and registers the result as the MEM/WB pipeline register.

## Interface
- DATA_W, 32, data/address width (`RegBus`)
- RADDR_W, 5, register address width (`RegAddrBus`)
- TIMEOUT, 16, maximum BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- mem_sw_o  in  DATA_W  store data from EXE/MEM
- mem_write_o  in  DATA_W  move-source data
- mem_lwsrc  in  1  1 = writeback selects load data
- mem_movsrc  in  1  1 = writeback selects mem_write_o; 0 = mem_alu_result (when mem_lwsrc=0)
- mem_write_addr_o  in  RADDR_W  destination register
- mem_reg_write  in  1  register write enable
- mem_DM_read  in  1  load request
- mem_DM_write  in  1  store request
- mem_alu_result  in  DATA_W  ALU result / memory address
- dm_req  out  1  memory request, held until acknowledged
- dm_we  out  1  1 = store, 0 = load
- dm_addr  out  DATA_W  access address
- dm_wdata  out  DATA_W  store data
- dm_rdata  in  DATA_W  load data, valid with dm_ack
- dm_ack  in  1  single-cycle completion strobe
- mem_stall  out  1  combinational; upstream registers hold while 1
- wb_write_data  out  DATA_W  registered writeback value
- wb_write_addr  out  RADDR_W  registered destination
- wb_reg_write  out  1  registered writeback enable
- mem_fault  out  1  one-cycle pulse on access timeout (0 when feature compiled out)

## Operation
- The FSM has two states, IDLE and BUSY. An access is pending when mem_DM_read or mem_DM_write is set.
- IDLE, no access:
  - mem_stall=0.
  - WB registers load the muxed value, mem_write_addr_o and mem_reg_write.
- IDLE, access pending:
  - mem_stall=1.
  - WB registers load wb_reg_write=0, which inserts a bubble.
  - On the edge, capture dm_addr=mem_alu_result, dm_wdata=mem_sw_o and dm_we=mem_DM_write, set dm_req=1, and go to BUSY.
  - If both mem_DM_read and mem_DM_write are set, the access is a store.
- BUSY, dm_ack=0:
  - mem_stall=1, wb_reg_write=0, and dm_req, dm_addr, dm_wdata and dm_we stay stable.
- BUSY, dm_ack=1:
  - mem_stall=0.
  - WB registers load the mux value with the load data taken from dm_rdata that cycle.
  - On the edge, dm_req=0 and the FSM returns to IDLE.
- Writeback mux: mem_lwsrc=1 selects load data; otherwise mem_movsrc=1 selects mem_write_o; otherwise mem_alu_result.
- A store writes back only if mem_reg_write=1, and the value then follows the same mux.
- dm_ack is ignored in IDLE.
- Asserting rst=0 at any time, including mid-access, immediately forces:
  - state=IDLE;
  - dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0;
  - wb_write_data=0, wb_write_addr=0, wb_reg_write=0;
  - mem_fault=0.

## Timing
- Non-memory instruction: WB outputs are updated at the edge ending the cycle in which the instruction is presented (1-cycle latency).
- Load or store: presented in cycle 0; dm_req rises after edge 0; the earliest dm_ack is in cycle 1.
  - WB is updated at the ack edge.
  - mem_stall is 1 from cycle 0 through every cycle before the ack, and 0 in the ack cycle.
  - Minimum occupancy is 2 cycles; each additional wait cycle adds 1.
- Back-to-back accesses: after the ack edge the FSM is in IDLE with the next instruction present; a following access starts there with no extra dead cycle.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - In the BUSY cycle where the count equals TIMEOUT-1 and dm_ack=0, mem_stall=0 and wb_reg_write loads 0.
  - At that edge dm_req drops, the state goes to IDLE, and mem_fault pulses to 1 for one cycle.
  - A dm_ack arriving in that same cycle wins, and no fault is raised.
- MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; mem_fault is tied to 0.

## Test plan
- ALU op, mem_lwsrc=0, mem_movsrc=0, mem_alu_result=0x0000_1234, addr=5, mem_reg_write=1 -> next edge wb_write_data=0x1234, wb_write_addr=5, wb_reg_write=1, mem_stall never 1.
- Load addr 0x40, dm_ack after 3 wait cycles, dm_rdata=0xDEAD_BEEF, mem_lwsrc=1 -> dm_req high 4 cycles, dm_we=0, dm_addr=0x40, mem_stall high 4 cycles (0 in the ack cycle), wb_write_data=0xDEADBEEF, wb_reg_write=1 after the ack edge.
- Store mem_sw_o=0xA5A5_A5A5 to 0x80, ack on the first BUSY cycle -> dm_we=1, dm_wdata=0xA5A5A5A5, wb_reg_write=0, total stall 1 cycle.
- Move, mem_movsrc=1, mem_write_o=0x77 followed immediately by a load -> wb_write_data=0x77 next edge, then the load stalls correctly with no lost instruction.
- rst=0 asserted mid-BUSY -> dm_req=0 and all outputs 0 immediately without a clock edge; after release the FSM is in IDLE, and a stray dm_ack is ignored.
- With MEM_TIMEOUT_EN, TIMEOUT=16, no ack -> 16 stall cycles, mem_fault=1 for exactly 1 cycle, wb_reg_write=0, FSM back in IDLE.
